// File: rtl/rv32i_single_cycle_soc.sv
// Single-cycle RV32I system: core, byte-lane instruction memory and byte-lane data memory.
// Defining RV32I_CSR_COUNTER_EN adds the cycle/instret counters readable through CSRRS.

module rv_mem #(
   parameter int WORDS = 16384,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [7:0] Memory_byte0 [0:WORDS-1];
   logic [7:0] Memory_byte1 [0:WORDS-1];
   logic [7:0] Memory_byte2 [0:WORDS-1];
   logic [7:0] Memory_byte3 [0:WORDS-1];

   assign rdata = {Memory_byte3[addr], Memory_byte2[addr], Memory_byte1[addr], Memory_byte0[addr]};

   always_ff @(posedge clk) begin
      if (we && be[0]) Memory_byte0[addr] <= wdata[7:0];
      if (we && be[1]) Memory_byte1[addr] <= wdata[15:8];
      if (we && be[2]) Memory_byte2[addr] <= wdata[23:16];
      if (we && be[3]) Memory_byte3[addr] <= wdata[31:24];
   end
endmodule

module rv_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);
   logic [31:0] Reg_Data [0:31];

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : Reg_Data[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : Reg_Data[raddr2];

   always_ff @(posedge clk) begin
      if (we && waddr != 5'd0) Reg_Data[waddr] <= wdata;
   end
endmodule

module rv_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   output logic [31:0] pc,
   input  logic [31:0] dm_rdata,
   output logic [31:0] dm_addr,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, pc_plus4, next_pc;
   logic [31:0] rd_val, alu_b, alu_y;
   logic        rd_we, st_en, alu_alt, taken;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Writes are suppressed while rst is high so a reset aborts the instruction in flight.
   rv_regfile i_RF (
      .clk    (clk),
      .we     (rd_we & ~rst),
      .waddr  (rd),
      .wdata  (rd_val),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val)
   );

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'b000:  r = alt ? (a - b) : (a + b);
         3'b001:  r = a << b[4:0];
         3'b010:  r = {31'd0, $signed(a) < $signed(b)};
         3'b011:  r = {31'd0, a < b};
         3'b100:  r = a ^ b;
         3'b101: begin
            if (alt) r = $signed(a) >>> b[4:0];
            else     r = a >> b[4:0];
         end
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   assign pc_plus4 = pc + 32'd4;
   assign dm_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign dm_we    = st_en & ~rst;
   assign alu_b    = (opcode == OP_REG) ? rs2_val : imm_i;
   // Immediate ops only treat bit 30 as the alternate select for the right shifts.
   assign alu_alt  = (opcode == OP_REG) ? instr[30] : (f3 == 3'b101 && instr[30]);
   assign alu_y    = alu_f(f3, alu_alt, rs1_val, alu_b);

   assign ld_half = dm_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
   always_comb begin
      case (dm_addr[1:0])
         2'd0:    ld_byte = dm_rdata[7:0];
         2'd1:    ld_byte = dm_rdata[15:8];
         2'd2:    ld_byte = dm_rdata[23:16];
         default: ld_byte = dm_rdata[31:24];
      endcase
   end

`ifdef RV32I_CSR_COUNTER_EN
   logic [63:0] cycle_cnt, instret_cnt;
   logic [31:0] csr_val;

   // Every non-reset cycle retires exactly one instruction, so both counters advance together.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt   <= cycle_cnt + 64'd1;
         instret_cnt <= instret_cnt + 64'd1;
      end
   end

   always_comb begin
      csr_val = '0;
      if (f3 == 3'b010 && rs1 == 5'd0) begin
         case (instr[31:20])
            12'hC00: csr_val = cycle_cnt[31:0];
            12'hC80: csr_val = cycle_cnt[63:32];
            12'hC02: csr_val = instret_cnt[31:0];
            12'hC82: csr_val = instret_cnt[63:32];
            default: csr_val = '0;
         endcase
      end
   end
`endif

   always_comb begin
      next_pc  = pc_plus4;
      rd_we    = 1'b0;
      rd_val   = '0;
      st_en    = 1'b0;
      dm_be    = 4'b0000;
      dm_wdata = '0;
      taken    = 1'b0;
      case (opcode)
         OP_LUI: begin
            rd_we  = 1'b1;
            rd_val = imm_u;
         end
         OP_AUIPC: begin
            rd_we  = 1'b1;
            rd_val = pc + imm_u;
         end
         OP_JAL: begin
            rd_we   = 1'b1;
            rd_val  = pc_plus4;
            next_pc = pc + imm_j;
         end
         OP_JALR: begin
            if (f3 == 3'b000) begin
               rd_we   = 1'b1;
               rd_val  = pc_plus4;
               next_pc = (rs1_val + imm_i) & ~32'd1;
            end
         end
         OP_BRANCH: begin
            case (f3)
               3'b000:  taken = (rs1_val == rs2_val);
               3'b001:  taken = (rs1_val != rs2_val);
               3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
               3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
               3'b110:  taken = (rs1_val <  rs2_val);
               3'b111:  taken = (rs1_val >= rs2_val);
               default: taken = 1'b0;
            endcase
            if (taken) next_pc = pc + imm_b;
         end
         OP_LOAD: begin
            case (f3)
               3'b000: begin rd_we = 1'b1; rd_val = {{24{ld_byte[7]}}, ld_byte}; end
               3'b001: begin rd_we = 1'b1; rd_val = {{16{ld_half[15]}}, ld_half}; end
               3'b010: begin rd_we = 1'b1; rd_val = dm_rdata; end
               3'b100: begin rd_we = 1'b1; rd_val = {24'd0, ld_byte}; end
               3'b101: begin rd_we = 1'b1; rd_val = {16'd0, ld_half}; end
               default: ;
            endcase
         end
         OP_STORE: begin
            // Misaligned stores fall back to the aligned-down lanes.
            case (f3)
               3'b000: begin
                  st_en    = 1'b1;
                  dm_wdata = {4{rs2_val[7:0]}};
                  dm_be    = 4'b0001 << dm_addr[1:0];
               end
               3'b001: begin
                  st_en    = 1'b1;
                  dm_wdata = {2{rs2_val[15:0]}};
                  dm_be    = dm_addr[1] ? 4'b1100 : 4'b0011;
               end
               3'b010: begin
                  st_en    = 1'b1;
                  dm_wdata = rs2_val;
                  dm_be    = 4'b1111;
               end
               default: ;
            endcase
         end
         OP_IMM: begin
            if ((f3 != 3'b001 && f3 != 3'b101) || f7 == 7'b0000000 ||
                (f3 == 3'b101 && f7 == 7'b0100000)) begin
               rd_we  = 1'b1;
               rd_val = alu_y;
            end
         end
         OP_REG: begin
            if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
               rd_we  = 1'b1;
               rd_val = alu_y;
            end
         end
`ifdef RV32I_CSR_COUNTER_EN
         OP_SYSTEM: begin
            if (f3 != 3'b000 && f3 != 3'b100) begin
               rd_we  = 1'b1;
               rd_val = csr_val;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) pc <= RESET_PC;
      else     pc <= next_pc;
   end
endmodule

module rv32i_single_cycle_soc #(
   parameter int          IM_WORDS = 16384,
   parameter int          DM_WORDS = 16384,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic clk,
   input logic rst
);
   localparam int IM_AW = $clog2(IM_WORDS);
   localparam int DM_AW = $clog2(DM_WORDS);

   logic [31:0] pc, instr, dm_addr, dm_rdata, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_we;
   logic        unused_bits;

   // Only the in-window address bits select a word; the rest wrap.
   assign unused_bits = &{1'b0, pc[31:IM_AW+2], pc[1:0], dm_addr[31:DM_AW+2]};

   rv_cpu #(.RESET_PC(RESET_PC)) i_CPU (
      .clk      (clk),
      .rst      (rst),
      .instr    (instr),
      .pc       (pc),
      .dm_rdata (dm_rdata),
      .dm_addr  (dm_addr),
      .dm_we    (dm_we),
      .dm_be    (dm_be),
      .dm_wdata (dm_wdata)
   );

   rv_mem #(.WORDS(IM_WORDS)) i_IM (
      .clk   (clk),
      .addr  (pc[IM_AW+1:2]),
      .we    (1'b0),
      .be    (4'b0000),
      .wdata (32'd0),
      .rdata (instr)
   );

   rv_mem #(.WORDS(DM_WORDS)) i_DM (
      .clk   (clk),
      .addr  (dm_addr[DM_AW+1:2]),
      .we    (dm_we),
      .be    (dm_be),
      .wdata (dm_wdata),
      .rdata (dm_rdata)
   );
endmodule

// File: tb/tb_rv32i_single_cycle_soc.sv
// Directed bench for rv32i_single_cycle_soc: small hand-assembled programs are loaded into the
// memories by hierarchy and registers, memory words and PC are compared to hand-computed values.

module tb_rv32i_single_cycle_soc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] prog[$];
   logic [31:0] exp_q[$];

   rv32i_single_cycle_soc dut (.clk(clk), .rst(rst));

   always #5 clk = ~clk;

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(int imm, int rd, int op);
      return {imm[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 'h13);
   endfunction
   function automatic logic [31:0] lui(int rd, int imm);
      return enc_u(imm, rd, 'h37);
   endfunction

   // ---------------- memory/register access ----------------
   task automatic put_im(int idx, logic [31:0] w);
      dut.i_IM.Memory_byte0[idx] <= w[7:0];
      dut.i_IM.Memory_byte1[idx] <= w[15:8];
      dut.i_IM.Memory_byte2[idx] <= w[23:16];
      dut.i_IM.Memory_byte3[idx] <= w[31:24];
   endtask
   task automatic put_dm(int idx, logic [31:0] w);
      dut.i_DM.Memory_byte0[idx] <= w[7:0];
      dut.i_DM.Memory_byte1[idx] <= w[15:8];
      dut.i_DM.Memory_byte2[idx] <= w[23:16];
      dut.i_DM.Memory_byte3[idx] <= w[31:24];
   endtask
   function automatic logic [31:0] dm_word(int idx);
      return {dut.i_DM.Memory_byte3[idx], dut.i_DM.Memory_byte2[idx],
              dut.i_DM.Memory_byte1[idx], dut.i_DM.Memory_byte0[idx]};
   endfunction
   function automatic logic [31:0] xreg(int n);
      return dut.i_CPU.i_RF.Reg_Data[n];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic add(logic [31:0] w);
      prog.push_back(w);
   endtask
   task automatic load_prog();
      for (int i = 0; i < prog.size(); i++) put_im(i, prog[i]);
      prog.delete();
   endtask
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // Caller raises rst and preloads memories; one reset edge, then release.
   task automatic reset_release();
      step(1);
      rst = 1'b0;
   endtask

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   initial begin
      int cyc;
      // ---- test 1: basic ADDI and x0 ----
      rst = 1'b1;
      add(addi(1, 0, 5));
      add(addi(2, 1, -7));
      add(addi(0, 0, 9));
      add(addi(3, 0, 0));
      add(enc_j(0, 0));
      load_prog();
      step(1);
      check("reset_pc", dut.i_CPU.pc, 32'h0);
      reset_release();
      step(2);
      check("addi_x1", xreg(1), 32'd5);
      check("addi_x2", xreg(2), 32'hFFFF_FFFE);
      check("pc_after_2", dut.i_CPU.pc, 32'd8);
      step(3);
      check("x0_reg", xreg(0), 32'd0);
      check("x0_read", xreg(3), 32'd0);

      // ---- test 2: byte lanes and wrap ----
      rst = 1'b1;
      add(lui(5, 'h8));
      add(addi(6, 0, 'h80));
      add(enc_s(1, 6, 5, 0));
      add(lui(7, 'h1));
      add(addi(7, 7, 'h234));
      add(enc_s(2, 7, 5, 1));
      add(enc_i(1, 5, 0, 8, 'h03));
      add(enc_i(1, 5, 4, 9, 'h03));
      add(enc_i(2, 5, 1, 11, 'h03));
      add(enc_s(5, 6, 5, 1));
      add(enc_i(7, 5, 1, 12, 'h03));
      add(lui(13, 'h18));
      add(enc_i(0, 13, 2, 14, 'h03));
      add(enc_j(0, 0));
      load_prog();
      put_dm('h2000, 32'h0);
      put_dm('h2001, 32'hA5A5_A5A5);
      reset_release();
      step(20);
      check("lanes_word", dm_word('h2000), 32'h1234_8000);
      check("lb", xreg(8), 32'hFFFF_FF80);
      check("lbu", xreg(9), 32'h0000_0080);
      check("lh", xreg(11), 32'h0000_1234);
      check("sh_misalign", dm_word('h2001), 32'hA5A5_0080);
      check("lh_misalign", xreg(12), 32'hFFFF_A5A5);
      check("lw_wrap", xreg(14), 32'h1234_8000);

      // ---- test 3: branches and jumps ----
      rst = 1'b1;
      add(addi(1, 0, -1));
      add(addi(2, 0, 1));
      add(addi(3, 0, 0));
      add(addi(4, 0, 0));
      add(enc_b(8, 2, 1, 4));
      add(addi(3, 0, 7));
      add(enc_b(8, 2, 1, 6));
      add(addi(4, 0, 9));
      add(enc_j(8, 5));
      add(addi(3, 0, 3));
      add(addi(6, 0, 61));
      add(enc_i(0, 6, 0, 7, 'h67));
      add(addi(3, 0, 5));
      add(addi(3, 0, 5));
      add(addi(3, 0, 6));
      add(addi(8, 0, 1));
      add(enc_j(0, 0));
      load_prog();
      reset_release();
      step(30);
      check("blt_taken", xreg(3), 32'd0);
      check("bltu_not", xreg(4), 32'd9);
      check("jal_link", xreg(5), 32'd36);
      check("jalr_link", xreg(7), 32'd48);
      check("jalr_land", xreg(8), 32'd1);
      check("spin_pc3", dut.i_CPU.pc, 32'd64);

      // ---- test 4: shifts, compares, NOPs ----
      rst = 1'b1;
      add(addi(12, 0, 77));
      add(addi(14, 0, 55));
      add(lui(1, 'h80000));
      add(enc_i('h404, 1, 5, 2, 'h13));
      add(enc_i(4, 1, 5, 3, 'h13));
      add(addi(4, 0, 1));
      add(addi(5, 0, -1));
      add(enc_r(0, 5, 4, 3, 6));
      add(enc_r(32, 4, 0, 0, 7));
      add(enc_r(0, 5, 4, 2, 8));
      add(addi(9, 0, 36));
      add(enc_r(0, 9, 4, 1, 10));
      add(enc_r(32, 9, 1, 5, 11));
      add(32'h0000_0073);
      add(32'h0FF0_000F);
      add(enc_r(1, 4, 4, 0, 12));
      add(enc_i('h401, 4, 1, 13, 'h13));
      add(enc_i('hC00, 0, 2, 14, 'h73));
      add(enc_j(0, 0));
      load_prog();
      reset_release();
      step(25);
      check("srai", xreg(2), 32'hF800_0000);
      check("srli", xreg(3), 32'h0800_0000);
      check("sltu", xreg(6), 32'd1);
      check("sub", xreg(7), 32'hFFFF_FFFF);
      check("slt", xreg(8), 32'd0);
      check("sll_mod32", xreg(10), 32'd16);
      check("sra_mod32", xreg(11), 32'hF800_0000);
      check("illegal_op", xreg(12), 32'd77);
      check("illegal_slli", xreg(13), 32'h0001_8000);
`ifdef RV32I_CSR_COUNTER_EN
      check("csr_cycle", xreg(14), 32'd17);
`else
      check("csr_nop", xreg(14), 32'd55);
`endif
      check("spin_pc4", dut.i_CPU.pc, 32'd72);

      // ---- test 5: end-marker flow ----
      rst = 1'b1;
      add(lui(5, 'h8));
      add(addi(1, 0, 0));
      add(addi(2, 0, 10));
      add(enc_r(0, 2, 1, 0, 1));
      add(addi(2, 2, -1));
      add(enc_b(-8, 0, 2, 1));
      add(enc_s(0, 1, 5, 2));
      add(enc_i(8, 1, 1, 3, 'h13));
      add(enc_s(4, 3, 5, 2));
      add(enc_i(-1, 3, 4, 4, 'h13));
      add(enc_s(8, 4, 5, 2));
      add(enc_u('h1, 6, 'h17));
      add(enc_s(12, 6, 5, 2));
      add(enc_i('h7F0, 4, 7, 7, 'h13));
      add(enc_i('h00F, 7, 6, 7, 'h13));
      add(enc_s(16, 7, 5, 2));
      add(addi(8, 0, -1));
      add(lui(9, 'h10));
      add(enc_s(-4, 8, 9, 2));
      add(enc_j(0, 0));
      load_prog();
      for (int i = 0; i < 5; i++) put_dm('h2000 + i, 32'h0);
      put_dm('h3FFF, 32'h0);
      exp_q.push_back(32'd55);
      exp_q.push_back(32'h0000_3700);
      exp_q.push_back(32'hFFFF_C8FF);
      exp_q.push_back(32'h0000_102C);
      exp_q.push_back(32'h0000_00FF);
      reset_release();
      cyc = 0;
      while (dm_word('h3FFF) !== 32'hFFFF_FFFF && cyc < 5000) begin
         step(1);
         cyc++;
      end
      check("end_marker", dm_word('h3FFF), 32'hFFFF_FFFF);
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         check($sformatf("golden_%0d", i), dm_word('h2000 + i), e);
      end

      // ---- test 6: mid-run reset aborts writes ----
      rst = 1'b1;
      add(lui(5, 'h8));
      add(addi(1, 0, 'h55));
      add(enc_s(0, 1, 5, 2));
      add(enc_s(4, 1, 5, 2));
      add(enc_j(0, 0));
      load_prog();
      put_dm('h2000, 32'h1111_1111);
      put_dm('h2001, 32'h2222_2222);
      reset_release();
      step(1);
      rst = 1'b1;
      step(1);
      check("abort_regwr", xreg(1), 32'h0000_0037);
      check("abort_pc1", dut.i_CPU.pc, 32'd0);
      rst = 1'b0;
      step(2);
      check("rerun_x1", xreg(1), 32'h0000_0055);
      rst = 1'b1;
      step(1);
      check("abort_store", dm_word('h2000), 32'h1111_1111);
      check("abort_pc2", dut.i_CPU.pc, 32'd0);
      rst = 1'b0;
      step(3);
      check("pc_after_rerun", dut.i_CPU.pc, 32'd12);
      check("store_done", dm_word('h2000), 32'h0000_0055);
      check("neighbor_kept", dm_word('h2001), 32'h2222_2222);
      step(1);
      check("store2_done", dm_word('h2001), 32'h0000_0055);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
